// File: rtl/jpeg_ff_stuffer.sv
// Pops encoded-chunk words from the FF-check FIFO, escapes every 0xFF data byte
// with a trailing 0x00, and repacks the byte stream into 32-bit output words.
module jpeg_ff_stuffer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  input  logic [90:0] fifo_rdata,
  input  logic        fifo_rdata_valid,
  output logic        read_req,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_last,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [1:0]  state;
  logic [79:0] hold;
  logic [3:0]  byte_idx;
  logic [3:0]  nbytes;
  logic        eof;
  logic        stuff_pending;
  logic [31:0] acc;
  logic [1:0]  acc_cnt;

  logic [7:0]  data_byte;
  logic [7:0]  off_byte;
  logic        word_done;
  logic        offer;
  logic        out_free;
  logic        accept;
  logic        is_ff;
  logic        final_byte;
  logic        full_load;
  logic        flush_load;
  logic [3:0]  rd_count;

  // Handshake: a word transfers on a rising edge where out_valid && out_ready;
  // the output register holds its contents until that transfer happens.
  always_comb begin
    data_byte = 8'h00;
    for (int i = 0; i < 10; i++) begin
      if (byte_idx == 4'(i)) data_byte = hold[79-8*i -: 8];
    end
  end

  assign word_done  = (byte_idx == nbytes) && !stuff_pending;
  assign offer      = (state == EMIT) && !word_done;
  assign off_byte   = stuff_pending ? 8'h00 : data_byte;
  assign out_free   = !out_valid || out_ready;
  assign accept     = offer && ((acc_cnt != 2'd3) || out_free);
  assign is_ff      = !stuff_pending && (data_byte == 8'hFF);
  // The last byte of an image is the final data byte (or its stuffing byte) of an eof word.
  assign final_byte = eof && !is_ff && ((byte_idx + 4'd1) == nbytes);
  assign full_load  = accept && (acc_cnt == 2'd3);
  assign flush_load = (state == FLUSH) && (acc_cnt != 2'd0) && out_free;
  assign read_req   = rst_n && (state == IDLE) && !fifo_empty;
  assign rd_count   = fifo_rdata[89:86];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      byte_idx      <= '0;
      nbytes        <= '0;
      eof           <= 1'b0;
      stuff_pending <= 1'b0;
      acc           <= '0;
      acc_cnt       <= '0;
      out_data      <= '0;
      out_bytes     <= '0;
      out_last      <= 1'b0;
      out_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req) state <= WAIT;
        end
        WAIT: begin
          if (fifo_rdata_valid) begin
            hold          <= fifo_rdata[79:0];
            byte_idx      <= '0;
            nbytes        <= (rd_count > 4'd10) ? 4'd10 : rd_count;
            eof           <= fifo_rdata[90];
            stuff_pending <= 1'b0;
            state         <= EMIT;
          end
        end
        EMIT: begin
          if (word_done) begin
            state <= eof ? FLUSH : IDLE;
          end else if (accept) begin
            if (is_ff) begin
              stuff_pending <= 1'b1;
            end else begin
              stuff_pending <= 1'b0;
              byte_idx      <= byte_idx + 4'd1;
            end
          end
        end
        FLUSH: begin
          if ((acc_cnt == 2'd0) || flush_load) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (accept) begin
        case (acc_cnt)
          2'd0: begin acc[31:24] <= off_byte; acc_cnt <= 2'd1; end
          2'd1: begin acc[23:16] <= off_byte; acc_cnt <= 2'd2; end
          2'd2: begin acc[15:8]  <= off_byte; acc_cnt <= 2'd3; end
          default: begin acc <= '0; acc_cnt <= 2'd0; end
        endcase
      end else if (flush_load) begin
        acc     <= '0;
        acc_cnt <= 2'd0;
      end

      if (full_load) begin
        out_data  <= {acc[31:8], off_byte};
        out_bytes <= 3'd4;
        out_last  <= final_byte;
        out_valid <= 1'b1;
      end else if (flush_load) begin
        out_data  <= acc;
        out_bytes <= {1'b0, acc_cnt};
        out_last  <= 1'b1;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jpeg_ff_stuffer.sv
// Directed bench for jpeg_ff_stuffer: a FIFO model feeds words, expected output
// words go into exp_q, and a negedge monitor pops and compares each transfer.
module tb_jpeg_ff_stuffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty = 1'b1;
  logic [90:0] fifo_rdata = '0;
  logic        fifo_rdata_valid = 1'b0;
  logic        read_req;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int errors = 0;
  int pop_count = 0;

  logic [35:0] exp_q[$];
  logic [90:0] fifo_q[$];
  logic        stalled_prev = 1'b0;
  logic [35:0] held = '0;

  jpeg_ff_stuffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fifo_empty       (fifo_empty),
    .fifo_rdata       (fifo_rdata),
    .fifo_rdata_valid (fifo_rdata_valid),
    .read_req         (read_req),
    .out_data         (out_data),
    .out_bytes        (out_bytes),
    .out_last         (out_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // FIFO model: data returns one cycle after read_req
  always @(posedge clk) begin
    fifo_rdata_valid <= 1'b0;
    if (read_req && fifo_q.size() > 0) begin
      fifo_rdata       <= fifo_q.pop_front();
      fifo_rdata_valid <= 1'b1;
      pop_count        <= pop_count + 1;
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [35:0] got;
    logic [35:0] exp;
    got = {out_last, out_bytes, out_data};
    if (rst_n && stalled_prev) begin
      checks++;
      if (!out_valid || got !== held) begin
        errors++;
        $display("FAIL hold_stable: got valid=%0b word=%h, required valid=1 word=%h", out_valid, got, held);
      end
    end
    stalled_prev = rst_n && out_valid && !out_ready;
    held         = got;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got last=%0b bytes=%0d data=%h, required none", out_last, out_bytes, out_data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL out_word: got last=%0b bytes=%0d data=%h, required last=%0b bytes=%0d data=%h",
                   out_last, out_bytes, out_data, exp[35], exp[34:32], exp[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic eof, input logic [3:0] cnt, input logic [5:0] rsvd, input logic [79:0] data);
    fifo_q.push_back({eof, cnt, rsvd, data});
  endtask

  task automatic expect_word(input logic last, input logic [2:0] nb, input logic [31:0] data);
    exp_q.push_back({last, nb, data});
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d words pending, required 0", name, exp_q.size());
      exp_q.delete();
      fifo_q.delete();
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    int pc0;
    int n;
    rst_n     = 1'b0;
    out_ready = 1'b1;

    // reset with FIFO non-empty; plain word 01..08
    push_word(1'b1, 4'd8, 6'h00, 80'h0102030405060708_0000);
    expect_word(1'b0, 3'd4, 32'h01020304);
    expect_word(1'b1, 3'd4, 32'h05060708);
    pc0 = pop_count;
    repeat (3) begin
      @(posedge clk); #1;
      check_val("reset_read_req", {31'd0, read_req}, 32'd0);
      check_val("reset_out_valid", {31'd0, out_valid}, 32'd0);
    end
    check_val("reset_out_data", out_data, 32'd0);
    check_val("reset_out_bytes_last", {28'd0, out_bytes, out_last}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("first_read_req", {31'd0, read_req}, 32'd1);
    wait_drain("no_stuff");
    check_val("no_stuff_pops", pop_count - pc0, 32'd1);

    // stuffing: FF,12,FF
    push_word(1'b1, 4'd3, 6'h00, 80'hFF12FF00000000000000);
    expect_word(1'b0, 3'd4, 32'hFF0012FF);
    expect_word(1'b1, 3'd1, 32'h00000000);
    wait_drain("stuffing");

    // backpressure: ten bytes AA..B3 with out_ready low for 10 cycles
    out_ready = 1'b0;
    push_word(1'b1, 4'd10, 6'h00, 80'hAAABACADAEAFB0B1B2B3);
    expect_word(1'b0, 3'd4, 32'hAAABACAD);
    expect_word(1'b0, 3'd4, 32'hAEAFB0B1);
    expect_word(1'b1, 3'd2, 32'hB2B30000);
    repeat (10) @(posedge clk);
    #1;
    check_val("stall_valid", {31'd0, out_valid}, 32'd1);
    check_val("stall_data", out_data, 32'hAAABACAD);
    out_ready = 1'b1;
    wait_drain("backpressure");

    // cross-word packing with an empty middle word
    push_word(1'b0, 4'd3, 6'h00, 80'h11223300000000000000);
    push_word(1'b0, 4'd0, 6'h00, 80'h0);
    push_word(1'b1, 4'd2, 6'h00, 80'h44FF0000000000000000);
    expect_word(1'b0, 3'd4, 32'h11223344);
    expect_word(1'b1, 3'd2, 32'hFF000000);
    wait_drain("cross_word");

    // trailing FF completes an exact word; reserved bits set
    push_word(1'b1, 4'd3, 6'h3F, 80'h0102FF00000000000000);
    expect_word(1'b1, 3'd4, 32'h0102FF00);
    wait_drain("trailing_ff");

    // mid-stream reset with acc_cnt=2
    pc0 = pop_count;
    push_word(1'b0, 4'd4, 6'h00, 80'h01020304000000000000);
    n = 0;
    while (pop_count == pc0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("mid_reset_pop", pop_count - pc0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) begin
      check_val("post_reset_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
    end
    push_word(1'b1, 4'd5, 6'h00, 80'h21222324250000000000);
    expect_word(1'b0, 3'd4, 32'h21222324);
    expect_word(1'b1, 3'd1, 32'h25000000);
    wait_drain("after_reset");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
